alu_issue_stage: RTL

Decode/issue stage that drives the RV32I ALU: accepts one instruction per cycle with its PC and register-file read data, decodes OP, OP-IMM, LUI and AUIPC into an ALU operation code and two operands, and holds the result in a valid/ready pipeline register. It sits between fetch/register-read and execute, and is the producer of `op1`, `op2` and `alu_op` for the ALU. It also emits the writeback control (`rd`, `rd_we`) and flags every other opcode as illegal.

---
 rtl/rv32i_pkg.sv | 62 ++++++
 rtl/alu_op_decoder.sv | 102 ++++++++++
 rtl/alu_issue_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU operation codes, opcode/funct7 constants and
// the operand-select and occupancy encodings used by the issue stage.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    OP1_ZERO = 2'd0,
    OP1_RS1  = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_t;

  typedef enum logic [1:0] {
    OP2_ZERO = 2'd0,
    OP2_RS2  = 2'd1,
    OP2_IMM  = 2'd2
  } op2_sel_t;

  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_state_t;

  // alt selects the funct7=0100000 variant (SUB / SRA) where one exists.
  function automatic alu_op_t funct3_to_alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of an RV32I word into ALU op, operand sources and
// immediate; anything outside OP/OP-IMM/LUI/AUIPC is flagged illegal.
module alu_op_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0]     instr_i,
  output alu_op_t         alu_op_o,
  output op1_sel_t        op1_sel_o,
  output op2_sel_t        op2_sel_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_u_s;
  logic            legal_s;
  alu_op_t         op_s;
  op1_sel_t        op1_sel_s;
  op2_sel_t        op2_sel_s;
  logic [XLEN-1:0] imm_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign imm_i_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u_s  = {instr_i[31:12], 12'h000};
  assign rd_o     = instr_i[11:7];

  // Classify the instruction and choose its operation and operand sources.
  always_comb begin
    legal_s   = 1'b0;
    op_s      = ALU_ADD;
    op1_sel_s = OP1_ZERO;
    op2_sel_s = OP2_ZERO;
    imm_s     = '0;
    case (opcode_s)
      OPC_OP: begin
        op1_sel_s = OP1_RS1;
        op2_sel_s = OP2_RS2;
        if (funct7_s == F7_BASE) begin
          legal_s = 1'b1;
          op_s    = funct3_to_alu_op(funct3_s, 1'b0);
        end else if ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          legal_s = 1'b1;
          op_s    = funct3_to_alu_op(funct3_s, 1'b1);
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        op1_sel_s = OP1_RS1;
        op2_sel_s = OP2_IMM;
        imm_s     = imm_i_s;
        // Only the shifts constrain instr[31:25]; ADDI never becomes SUB.
        if (funct3_s == 3'b001) begin
          legal_s = (funct7_s == F7_BASE);
          op_s    = ALU_SLL;
        end else if (funct3_s == 3'b101) begin
          legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          op_s    = funct3_to_alu_op(funct3_s, funct7_s == F7_ALT);
        end else begin
          legal_s = 1'b1;
          op_s    = funct3_to_alu_op(funct3_s, 1'b0);
        end
      end
      OPC_LUI: begin
        legal_s   = 1'b1;
        op2_sel_s = OP2_IMM;
        imm_s     = imm_u_s;
      end
      OPC_AUIPC: begin
        legal_s   = 1'b1;
        op1_sel_s = OP1_PC;
        op2_sel_s = OP2_IMM;
        imm_s     = imm_u_s;
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Illegal words issue as a harmless ADD of two zero operands.
  always_comb begin
    if (legal_s) begin
      alu_op_o  = op_s;
      op1_sel_o = op1_sel_s;
      op2_sel_o = op2_sel_s;
      imm_o     = imm_s;
      illegal_o = 1'b0;
    end else begin
      alu_op_o  = ALU_ADD;
      op1_sel_o = OP1_ZERO;
      op2_sel_o = OP2_ZERO;
      imm_o     = '0;
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes one instruction per cycle into a single
// valid/ready output register feeding the ALU.
module alu_issue_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  alu_op_t         dec_op_s;
  op1_sel_t        dec_op1_sel_s;
  op2_sel_t        dec_op2_sel_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [4:0]      dec_rd_s;
  logic            dec_illegal_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
  logic            rd_we_s;

  occ_state_t      state_q, state_d;
  logic            load_s;

  alu_op_t         alu_op_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [4:0]      rd_q;
  logic            rd_we_q;
  logic            illegal_q;
  logic [XLEN-1:0] pc_q;

  alu_op_decoder u_dec (
    .instr_i   (in_instr),
    .alu_op_o  (dec_op_s),
    .op1_sel_o (dec_op1_sel_s),
    .op2_sel_o (dec_op2_sel_s),
    .imm_o     (dec_imm_s),
    .rd_o      (dec_rd_s),
    .illegal_o (dec_illegal_s)
  );

  // Operand muxes and writeback enable.
  always_comb begin
    op1_s = '0;
    op2_s = '0;
    case (dec_op1_sel_s)
      OP1_RS1: op1_s = in_rs1_data;
      OP1_PC:  op1_s = in_pc;
      default: op1_s = '0;
    endcase
    case (dec_op2_sel_s)
      OP2_RS2: op2_s = in_rs2_data;
      OP2_IMM: op2_s = dec_imm_s;
      default: op2_s = '0;
    endcase
    rd_we_s = !dec_illegal_s && (dec_rd_s != 5'd0);
  end

  assign in_ready = (state_q == OCC_EMPTY) || out_ready;

  // Occupancy next state; flush wins over a concurrent capture.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (flush) begin
          state_d = OCC_EMPTY;
        end else if (in_valid) begin
          state_d = OCC_FULL;
          load_s  = 1'b1;
        end else begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (flush) begin
          state_d = OCC_EMPTY;
        end else if (out_ready && in_valid) begin
          state_d = OCC_FULL;
          load_s  = 1'b1;
        end else if (out_ready) begin
          state_d = OCC_EMPTY;
        end else begin
          state_d = OCC_FULL;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue payload register; loads as a unit on capture, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_q  <= ALU_ADD;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= 5'd0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
    end else if (load_s) begin
      alu_op_q  <= dec_op_s;
      op1_q     <= op1_s;
      op2_q     <= op2_s;
      rd_q      <= dec_rd_s;
      rd_we_q   <= rd_we_s;
      illegal_q <= dec_illegal_s;
      pc_q      <= in_pc;
    end
  end

  assign out_valid   = (state_q == OCC_FULL);
  assign out_alu_op  = alu_op_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_illegal = illegal_q;
  assign out_pc      = pc_q;

endmodule
